// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache.
// The statistics counters are built only when CACHE_STATS_EN is defined.
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      BYPASS,
      WRITE,
      RESP
   } cache_state_t;

   localparam logic [31:0] DEFAULT_UNCACHED_BASE = 32'h5000_0000;

   function automatic int index_w(input int lines);
      return $clog2(lines);
   endfunction

   // Word-addressed cache: address bits [1:0] never take part in the tag.
   function automatic int tag_w(input int lines);
      return 30 - $clog2(lines);
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read by
// index, one synchronous write port, and a single-cycle invalidate-all.
module cache_line_store
   import cache_pkg::*;
#(
   parameter  int LINES = 64,
   localparam int IW    = index_w(LINES),
   localparam int TW    = tag_w(LINES)
) (
   input  logic          i_clock,
   input  logic          i_reset_n,
   input  logic [IW-1:0] i_rd_index,
   output logic          o_rd_valid,
   output logic [TW-1:0] o_rd_tag,
   output logic [31:0]   o_rd_data,
   input  logic          i_wr_en,
   input  logic [IW-1:0] i_wr_index,
   input  logic [TW-1:0] i_wr_tag,
   input  logic [31:0]   i_wr_data,
   input  logic          i_invalidate
);

   logic [LINES-1:0] valid_q;
   logic [TW-1:0]    tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   // Only the valid bits need reset; stale tag/data behind a clear bit is harmless.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         valid_q <= '0;
      end else if (i_invalidate) begin
         valid_q <= '0;
      end else if (i_wr_en) begin
         valid_q[i_wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_wr_en) begin
         tag_q[i_wr_index]  <= i_wr_tag;
         data_q[i_wr_index] <= i_wr_data;
      end
   end

   assign o_rd_valid = valid_q[i_rd_index];
   assign o_rd_tag   = tag_q[i_rd_index];
   assign o_rd_data  = data_q[i_rd_index];

endmodule

// File: rtl/cpu_dcache.sv
// Direct-mapped, write-through, read-allocate word cache between CPU and bus.
// Define CACHE_STATS_EN to add the saturating o_hits/o_misses counters.
module cpu_dcache
   import cache_pkg::*;
#(
   parameter  int          LINES         = 64,
   parameter  logic [31:0] UNCACHED_BASE = DEFAULT_UNCACHED_BASE,
   localparam int          IW            = index_w(LINES),
   localparam int          TW            = tag_w(LINES)
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_cpu_request,
   input  logic        i_cpu_rw,
   input  logic [31:0] i_cpu_address,
   input  logic [31:0] i_cpu_wdata,
   output logic [31:0] o_cpu_rdata,
   output logic        o_cpu_ready,
   output logic        o_bus_request,
   output logic        o_bus_rw,
   output logic [31:0] o_bus_address,
   output logic [31:0] o_bus_wdata,
   input  logic        i_bus_ready,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_flush
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0] o_hits,
   output logic [31:0] o_misses
`endif
);

   cache_state_t  state;
   logic          flush_pending;
   logic [29:0]   req_word;

   logic [IW-1:0] cpu_index;
   logic [TW-1:0] cpu_tag;
   logic [IW-1:0] req_index;
   logic [TW-1:0] req_tag;
   logic          cpu_cacheable;
   logic [IW-1:0] rd_index;
   logic          line_valid;
   logic [TW-1:0] line_tag;
   logic [31:0]   line_data;
   logic          lookup_hit;
   logic          flush_now;
   logic          idle_hit;
   logic          bus_done;
   logic          store_wr_en;
   logic [31:0]   store_wr_data;

   assign cpu_index     = i_cpu_address[2+IW-1:2];
   assign cpu_tag       = i_cpu_address[31:2+IW];
   assign req_index     = req_word[IW-1:0];
   assign req_tag       = req_word[29:IW];
   assign cpu_cacheable = (i_cpu_address < UNCACHED_BASE);

   // Look up the incoming address in IDLE, the latched one while busy.
   assign rd_index   = (state == IDLE) ? cpu_index : req_index;
   assign lookup_hit = line_valid && (line_tag == ((state == IDLE) ? cpu_tag : req_tag));

   // Flushes land only at IDLE/RESP so a completing FILL still writes first.
   assign flush_now     = (i_flush || flush_pending) && ((state == IDLE) || (state == RESP));
   assign idle_hit      = lookup_hit && !flush_now;
   assign bus_done      = o_bus_request && i_bus_ready;
   assign store_wr_en   = bus_done && ((state == FILL) || ((state == WRITE) && lookup_hit));
   assign store_wr_data = (state == FILL) ? i_bus_rdata : o_bus_wdata;

   cache_line_store #(
      .LINES (LINES)
   ) u_store (
      .i_clock      (i_clock),
      .i_reset_n    (i_reset_n),
      .i_rd_index   (rd_index),
      .o_rd_valid   (line_valid),
      .o_rd_tag     (line_tag),
      .o_rd_data    (line_data),
      .i_wr_en      (store_wr_en),
      .i_wr_index   (req_index),
      .i_wr_tag     (req_tag),
      .i_wr_data    (store_wr_data),
      .i_invalidate (flush_now)
   );

   always_ff @(posedge i_clock) begin
      if ((state == IDLE) && i_cpu_request) begin
         req_word <= i_cpu_address[31:2];
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= IDLE;
         flush_pending <= 1'b0;
         o_cpu_ready   <= 1'b0;
         o_cpu_rdata   <= '0;
         o_bus_request <= 1'b0;
         o_bus_rw      <= 1'b0;
         o_bus_address <= '0;
         o_bus_wdata   <= '0;
      end else begin
         if (flush_now) begin
            flush_pending <= 1'b0;
         end else if (i_flush) begin
            flush_pending <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (i_cpu_request) begin
                  o_bus_address <= {i_cpu_address[31:2], 2'b00};
                  o_bus_wdata   <= i_cpu_wdata;
                  o_bus_rw      <= i_cpu_rw;
                  if (i_cpu_rw) begin
                     state         <= WRITE;
                     o_bus_request <= 1'b1;
                  end else if (!cpu_cacheable) begin
                     state         <= BYPASS;
                     o_bus_request <= 1'b1;
                  end else if (idle_hit) begin
                     state       <= RESP;
                     o_cpu_ready <= 1'b1;
                     o_cpu_rdata <= line_data;
                  end else begin
                     state         <= FILL;
                     o_bus_request <= 1'b1;
                  end
               end
            end
            FILL, BYPASS, WRITE: begin
               if (bus_done) begin
                  state         <= RESP;
                  o_bus_request <= 1'b0;
                  o_cpu_ready   <= 1'b1;
                  o_cpu_rdata   <= (state == WRITE) ? 32'd0 : i_bus_rdata;
               end
            end
            RESP: begin
               state       <= IDLE;
               o_cpu_ready <= 1'b0;
               o_cpu_rdata <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_hits   <= '0;
         o_misses <= '0;
      end else if ((state == IDLE) && i_cpu_request && !i_cpu_rw && cpu_cacheable) begin
         if (idle_hit) begin
            o_hits <= sat_inc(o_hits);
         end else begin
            o_misses <= sat_inc(o_misses);
         end
      end
   end
`endif

endmodule

// File: tb/tb_cpu_dcache.sv
// Self-checking bench for cpu_dcache: directed scenarios plus a random mix,
// compared against a transparent-memory reference model.
module tb_cpu_dcache;

   localparam int LINES = 64;

   logic        i_clock;
   logic        i_reset_n;
   logic        i_cpu_request;
   logic        i_cpu_rw;
   logic [31:0] i_cpu_address;
   logic [31:0] i_cpu_wdata;
   logic [31:0] o_cpu_rdata;
   logic        o_cpu_ready;
   logic        o_bus_request;
   logic        o_bus_rw;
   logic [31:0] o_bus_address;
   logic [31:0] o_bus_wdata;
   logic        i_bus_ready;
   logic [31:0] i_bus_rdata;
   logic        i_flush;
`ifdef CACHE_STATS_EN
   logic [31:0] o_hits;
   logic [31:0] o_misses;
`endif

   cpu_dcache #(
      .LINES (LINES)
   ) dut (
      .i_clock       (i_clock),
      .i_reset_n     (i_reset_n),
      .i_cpu_request (i_cpu_request),
      .i_cpu_rw      (i_cpu_rw),
      .i_cpu_address (i_cpu_address),
      .i_cpu_wdata   (i_cpu_wdata),
      .o_cpu_rdata   (o_cpu_rdata),
      .o_cpu_ready   (o_cpu_ready),
      .o_bus_request (o_bus_request),
      .o_bus_rw      (o_bus_rw),
      .o_bus_address (o_bus_address),
      .o_bus_wdata   (o_bus_wdata),
      .i_bus_ready   (i_bus_ready),
      .i_bus_rdata   (i_bus_rdata),
      .i_flush       (i_flush)
`ifdef CACHE_STATS_EN
      ,
      .o_hits        (o_hits),
      .o_misses      (o_misses)
`endif
   );

   initial begin
      i_clock = 1'b0;
      forever #5 i_clock = ~i_clock;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int total = 0;
   int bad   = 0;

   // Reference: the cache must look like plain memory; the model only tracks
   // which word address each line would hold to predict hit versus miss.
   logic [31:0] mem [logic [29:0]];
   bit          mvalid [LINES];
   logic [29:0] mline  [LINES];
   int unsigned mhits   = 0;
   int unsigned mmisses = 0;

   function automatic logic [31:0] mem_get(input logic [29:0] w);
      if (!mem.exists(w)) mem[w] = $urandom;
      return mem[w];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_invalidate();
      for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
   endtask

   // Drives one CPU transaction and acts as the bus responder.
   task automatic access(input bit rw, input logic [31:0] addr, input logic [31:0] wd,
                         input int waits, input int flush_at,
                         output logic [31:0] rd, output int txn, output int lat,
                         output bit fields_ok, output bit timeout, output bit ready_after);
      int bus_cnt;
      bit done;
      bit prev_req;
      i_cpu_request = 1'b1;
      i_cpu_rw      = rw;
      i_cpu_address = addr;
      i_cpu_wdata   = wd;
      i_bus_ready   = 1'b0;
      bus_cnt = 0; txn = 0; lat = 0; done = 0; prev_req = 0;
      fields_ok = 1; timeout = 0; rd = '0;
      while (!done && lat < 60) begin
         @(posedge i_clock); #1;
         lat++;
         i_bus_ready = 1'b0;
         i_flush     = (lat == flush_at);
         if (o_cpu_ready) begin
            rd            = o_cpu_rdata;
            done          = 1;
            i_cpu_request = 1'b0;
         end else begin
            i_cpu_address = $urandom;
            i_cpu_wdata   = $urandom;
            if (o_bus_request) begin
               if (!prev_req) txn++;
               if (o_bus_rw !== rw || o_bus_address !== {addr[31:2], 2'b00} ||
                   (rw && o_bus_wdata !== wd)) fields_ok = 0;
               bus_cnt++;
               if (bus_cnt > waits) begin
                  i_bus_ready = 1'b1;
                  if (o_bus_rw) begin
                     mem[o_bus_address[31:2]] = o_bus_wdata;
                     i_bus_rdata = $urandom;
                  end else begin
                     i_bus_rdata = mem_get(o_bus_address[31:2]);
                  end
               end else begin
                  i_bus_rdata = $urandom;
               end
            end
         end
         prev_req = o_bus_request;
      end
      timeout = !done;
      i_cpu_request = 1'b0;
      @(posedge i_clock); #1;
      i_flush     = 1'b0;
      i_bus_ready = 1'b0;
      ready_after = o_cpu_ready;
   endtask

   task automatic run(input string tag, input bit rw, input logic [31:0] addr,
                      input logic [31:0] wd, input int waits, input int flush_at);
      logic [29:0] w;
      int idx;
      bit cacheable, hit;
      logic [31:0] rd;
      int txn, lat;
      bit ok, to, rdy2;
      w         = addr[31:2];
      idx       = int'(w % LINES);
      cacheable = (addr < 32'h5000_0000);
      hit       = !rw && cacheable && mvalid[idx] && (mline[idx] == w);
      access(rw, addr, wd, waits, flush_at, rd, txn, lat, ok, to, rdy2);
      check({tag, ":timeout"}, to, 1'b0);
      check({tag, ":bus_txn"}, txn, hit ? 0 : 1);
      check({tag, ":latency"}, lat, hit ? 1 : 2 + waits);
      check({tag, ":bus_fields"}, ok, 1'b1);
      check({tag, ":ready_pulse"}, rdy2, 1'b0);
      check({tag, ":rdata"}, rd, rw ? 32'd0 : mem_get(w));
      if (!rw && cacheable) begin
         if (hit) mhits++;
         else begin
            mmisses++;
            mvalid[idx] = 1'b1;
            mline[idx]  = w;
         end
      end
      if (flush_at > 0) model_invalidate();
   endtask

   task automatic pulse_flush();
      i_flush = 1'b1;
      @(posedge i_clock); #1;
      i_flush = 1'b0;
      model_invalidate();
   endtask

   initial begin
      bit seen;
      i_reset_n     = 1'b0;
      i_cpu_request = 1'b0;
      i_cpu_rw      = 1'b0;
      i_cpu_address = '0;
      i_cpu_wdata   = '0;
      i_bus_ready   = 1'b0;
      i_bus_rdata   = '0;
      i_flush       = 1'b0;
      model_invalidate();
      #12;
      check("reset:cpu_ready", o_cpu_ready, 1'b0);
      check("reset:cpu_rdata", o_cpu_rdata, 32'd0);
      check("reset:bus_request", o_bus_request, 1'b0);
      check("reset:bus_rw", o_bus_rw, 1'b0);
      check("reset:bus_address", o_bus_address, 32'd0);
      check("reset:bus_wdata", o_bus_wdata, 32'd0);
`ifdef CACHE_STATS_EN
      check("reset:hits", o_hits, 32'd0);
      check("reset:misses", o_misses, 32'd0);
`endif
      @(posedge i_clock); #1;
      i_reset_n = 1'b1;
      @(posedge i_clock); #1;

      mem[30'h0001_0040 >> 2] = 32'hDEAD_BEEF;
      run("rd_first", 0, 32'h0001_0040, 0, 2, 0);
      run("rd_hit", 0, 32'h0001_0040, 0, 0, 0);

      run("conflict_a", 0, 32'h0001_0140, 0, 1, 0);
      run("conflict_b", 0, 32'h0001_0040, 0, 0, 0);

      run("wr_hit", 1, 32'h0001_0040, 32'h1234_5678, 1, 0);
      check("wr_hit:mem", mem[30'h0001_0040 >> 2], 32'h1234_5678);
      run("rd_after_wr", 0, 32'h0001_0040, 0, 0, 0);
      run("wr_miss", 1, 32'h0001_0300, 32'hCAFE_0001, 0, 0);
      run("rd_after_wr_miss", 0, 32'h0001_0300, 0, 0, 0);

      run("uncached_1", 0, 32'h5000_0010, 0, 1, 0);
      run("uncached_2", 0, 32'h5000_0010, 0, 0, 0);

      run("flush_in_fill", 0, 32'h1000_0000, 0, 1, 1);
      run("refill_after_flush", 0, 32'h1000_0000, 0, 0, 0);
      run("flush_at_fill_end", 0, 32'h1000_0004, 0, 0, 1);
      run("refill_after_late_flush", 0, 32'h1000_0004, 0, 0, 0);

      run("idle_flush_fill", 0, 32'h0000_0200, 0, 0, 0);
      run("idle_flush_hit", 0, 32'h0000_0200, 0, 0, 0);
      pulse_flush();
      run("idle_flush_miss", 0, 32'h0000_0200, 0, 0, 0);

`ifdef CACHE_STATS_EN
      check("stats:hits", o_hits, mhits);
      check("stats:misses", o_misses, mmisses);
`endif

      // Reset while the bus request is outstanding.
      i_cpu_request = 1'b1;
      i_cpu_rw      = 1'b0;
      i_cpu_address = 32'h2000_0100;
      seen = 0;
      for (int k = 0; k < 6 && !seen; k++) begin
         @(posedge i_clock); #1;
         seen = o_bus_request;
      end
      check("rst_mid:bus_req_rose", seen, 1'b1);
      i_reset_n = 1'b0;
      #1;
      check("rst_mid:bus_request", o_bus_request, 1'b0);
      check("rst_mid:bus_address", o_bus_address, 32'd0);
      check("rst_mid:cpu_ready", o_cpu_ready, 1'b0);
      i_cpu_request = 1'b0;
      @(posedge i_clock); #1;
      i_reset_n = 1'b1;
      model_invalidate();
      mhits   = 0;
      mmisses = 0;
      run("rst_mid:reread", 0, 32'h2000_0100, 0, 0, 0);

      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         bit rw;
         if ($urandom_range(0, 99) < 15)
            a = 32'h5000_0000 + ($urandom_range(0, 7) << 2);
         else
            a = 32'h0002_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2)
                | $urandom_range(0, 3);
         rw = ($urandom_range(0, 99) < 25);
         run("random", rw, a, $urandom, $urandom_range(0, 3),
             ($urandom_range(0, 99) < 8) ? 1 : 0);
         if ($urandom_range(0, 99) < 5) pulse_flush();
      end

`ifdef CACHE_STATS_EN
      check("final:hits", o_hits, mhits);
      check("final:misses", o_misses, mmisses);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
